// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg
// Shared constants for the N-channel stream multiplexer.
//   MODE_SELECT / MODE_RR : values for the MODE parameter of stream_mux_n
//   sel_width()           : width of the channel-index fields (sel, out_chan)
package stream_mux_pkg;

  localparam int MODE_SELECT = 0;
  localparam int MODE_RR     = 1;

  // Never narrower than one bit, so a channel index always has a real port.
  function automatic int sel_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_mux_n_rr_arbiter.sv
// rr_arbiter
// Round-robin arbiter that owns the priority pointer.
//   clk, rst  : clock, synchronous active-high reset
//   req       : per-channel request (the input valids)
//   advance   : a transfer took place on the granted channel this cycle
//   grant     : one-hot grant, all zero when nothing requests
//   grant_idx : index of the granted channel (only meaningful when grant != 0)
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = sel_width(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] req,
  input  logic                advance,
  output logic [CHANNELS-1:0] grant,
  output logic [SEL_W-1:0]    grant_idx
);

  // Last channel served; the search starts just after it.
  logic [SEL_W-1:0] ptr;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 1; k <= CHANNELS; k++) begin
      int idx;
      idx = (int'(ptr) + k) % CHANNELS;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = SEL_W'(idx);
      end
    end
  end

  // Reset points at the last channel so channel 0 wins first.
  // Stalls and idle cycles leave the pointer alone.
  always_ff @(posedge clk) begin
    if (rst)
      ptr <= SEL_W'(CHANNELS - 1);
    else if (advance)
      ptr <= grant_idx;
  end

endmodule

// File: rtl/stream_mux_n.sv
// stream_mux_n
// N-channel registered stream multiplexer with valid/ready handshakes.
// Channel choice is either the sel input (MODE_SELECT) or round-robin (MODE_RR).
//   clk, rst  : clock, synchronous active-high reset
//   in_data   : CHANNELS packed words, channel i at [i*WIDTH +: WIDTH]
//   in_valid  : per-channel valid
//   in_ready  : per-channel ready (combinational from in_valid/sel/out_ready)
//   sel       : channel select, used in MODE_SELECT only
//   out_data  : registered output word
//   out_chan  : channel that supplied out_data
//   out_valid : output word valid
//   out_ready : consumer ready
module stream_mux_n
  import stream_mux_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  parameter  int MODE     = MODE_SELECT,
  localparam int SEL_W    = sel_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic                load;
  logic                xfer;
  logic [CHANNELS-1:0] gnt_ready;
  logic [SEL_W-1:0]    gnt_idx;
  logic [WIDTH-1:0]    mux_data;

  // Output register is empty or drains this cycle.
  assign load = !out_valid || out_ready;

  generate
    if (MODE == MODE_RR) begin : g_rr
      rr_arbiter #(.CHANNELS(CHANNELS), .SEL_W(SEL_W)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (in_valid),
        .advance   (xfer),
        .grant     (gnt_ready),
        .grant_idx (gnt_idx)
      );
    end else begin : g_sel
      // Ready is offered on sel regardless of its valid. An out-of-range sel
      // (non-power-of-2 CHANNELS) matches no bit, so nothing is offered.
      always_comb begin
        gnt_ready = '0;
        for (int i = 0; i < CHANNELS; i++)
          gnt_ready[i] = (sel == SEL_W'(i));
      end
      assign gnt_idx = sel;
    end
  endgenerate

  // Ready is withheld during reset so no upstream word is lost in that cycle.
  assign in_ready = (load && !rst) ? gnt_ready : '0;
  assign xfer     = |(in_valid & in_ready);
  assign mux_data = in_data[int'(gnt_idx)*WIDTH +: WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (load) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= mux_data;
        out_chan <= gnt_idx;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_n.sv
// tb_stream_mux_n
// Three instances share one stimulus stream: select mode with 4 channels,
// round-robin with 4 channels, and select mode with 3 channels (sel=3 is out
// of range there). A transaction-level model tracks each output register.
module tb_stream_mux_n;
  import stream_mux_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [1:0]  sel;
  logic        out_ready;

  logic [3:0] a_rdy, b_rdy;
  logic [2:0] c_rdy;
  logic [7:0] a_od, b_od, c_od;
  logic [1:0] a_oc, b_oc, c_oc;
  logic       a_ov, b_ov, c_ov;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  stream_mux_n #(.WIDTH(8), .CHANNELS(4), .MODE(MODE_SELECT)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(a_rdy),
    .sel(sel), .out_data(a_od), .out_chan(a_oc), .out_valid(a_ov), .out_ready(out_ready));

  stream_mux_n #(.WIDTH(8), .CHANNELS(4), .MODE(MODE_RR)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(b_rdy),
    .sel(sel), .out_data(b_od), .out_chan(b_oc), .out_valid(b_ov), .out_ready(out_ready));

  stream_mux_n #(.WIDTH(8), .CHANNELS(3), .MODE(MODE_SELECT)) dut_c (
    .clk(clk), .rst(rst), .in_data(in_data[23:0]), .in_valid(in_valid[2:0]), .in_ready(c_rdy),
    .sel(sel), .out_data(c_od), .out_chan(c_oc), .out_valid(c_ov), .out_ready(out_ready));

  // ---------------- reference model ----------------
  typedef struct {
    logic       v;
    logic [7:0] d;
    int         chan;
    int         ptr;
  } mst_t;

  mst_t ma, mb, mc;

  // Which channel may hand over a word this cycle.
  function automatic logic [3:0] m_ready(input int mode, input int ch, input mst_t s);
    logic [3:0] r = '0;
    int p;
    if (rst || (s.v && !out_ready)) return r;
    if (mode == MODE_SELECT) begin
      if (int'(sel) < ch) r[sel] = 1'b1;
    end else begin
      p = s.ptr;
      for (int k = 1; k <= ch; k++) begin
        p = (p + 1) % ch;
        if (in_valid[p]) begin
          r[p] = 1'b1;
          return r;
        end
      end
    end
    return r;
  endfunction

  function automatic mst_t m_next(input int mode, input int ch, input mst_t s, input logic [3:0] r);
    mst_t n = s;
    if (rst) begin
      n.v = 1'b0; n.d = 8'h00; n.chan = 0; n.ptr = ch - 1;
      return n;
    end
    if (!s.v || out_ready) begin
      n.v = 1'b0;
      for (int i = 0; i < ch; i++)
        if (r[i] && in_valid[i]) begin
          n.v    = 1'b1;
          n.d    = in_data[i*8 +: 8];
          n.chan = i;
          if (mode == MODE_RR) n.ptr = i;
        end
    end
    return n;
  endfunction

  // ---------------- stimulus plumbing ----------------
  task automatic apply(input logic r, input logic [3:0] v, input logic [1:0] s,
                       input logic ordy, input logic [31:0] d);
    rst = r; in_valid = v; sel = s; out_ready = ordy; in_data = d;
    #1;
  endtask

  task automatic advance();
    logic [3:0] ra, rb, rc;
    ra = m_ready(MODE_SELECT, 4, ma);
    rb = m_ready(MODE_RR, 4, mb);
    rc = m_ready(MODE_SELECT, 3, mc);
    ma = m_next(MODE_SELECT, 4, ma, ra);
    mb = m_next(MODE_RR, 4, mb, rb);
    mc = m_next(MODE_SELECT, 3, mc, rc);
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      apply(1'b1, 4'h0, 2'd0, 1'b1, $urandom);
      vectors++;
      if ({a_rdy, b_rdy, c_rdy} !== 11'b0) begin
        errs++; $display("FAIL reset_ready: got %b want 0", {a_rdy, b_rdy, c_rdy});
      end
      advance();
    end
    vectors++;
    if ({a_ov, a_od, a_oc, b_ov, b_od, b_oc, c_ov, c_od, c_oc} !== 33'b0) begin
      errs++; $display("FAIL reset_out: got %h want 0", {a_ov, a_od, a_oc, b_ov, b_od, b_oc, c_ov, c_od, c_oc});
    end
    // After reset the register is empty, so sel=0 is offered ready at once.
    apply(1'b0, 4'h0, 2'd0, 1'b1, 32'h0);
    vectors++;
    if (a_rdy !== 4'b0001) begin
      errs++; $display("FAIL reset_load_ready: got %b want 0001", a_rdy);
    end
  endtask

  task automatic test_sel_sweep();
    logic [7:0] exp_d [4] = '{8'h01, 8'h00, 8'h00, 8'h01};
    for (int s = 0; s < 4; s++) begin
      apply(1'b0, 4'hF, 2'(s), 1'b1, 32'h01000001);
      vectors++;
      if ({a_rdy, b_rdy, 1'b0, c_rdy} !== {m_ready(MODE_SELECT, 4, ma), m_ready(MODE_RR, 4, mb), m_ready(MODE_SELECT, 3, mc)}) begin
        errs++; $display("FAIL sweep_ready: got %b", {a_rdy, b_rdy, c_rdy});
      end
      advance();
      vectors++;
      if (a_ov !== 1'b1 || a_od !== exp_d[s] || a_oc !== 2'(s)) begin
        errs++; $display("FAIL sweep_out s=%0d: got v%b d%h c%0d want v1 d%h c%0d", s, a_ov, a_od, a_oc, exp_d[s], s);
      end
    end
  endtask

  task automatic test_rr_all();
    for (int k = 0; k < 8; k++) begin
      apply(1'b0, 4'hF, 2'($urandom), 1'b1, $urandom);
      vectors++;
      if (b_rdy !== 4'(1 << (k % 4))) begin
        errs++; $display("FAIL rr_all_ready k=%0d: got %b want %b", k, b_rdy, 4'(1 << (k % 4)));
      end
      advance();
      vectors++;
      if (b_ov !== 1'b1 || b_oc !== 2'(k % 4) || b_od !== mb.d) begin
        errs++; $display("FAIL rr_all_out k=%0d: got v%b c%0d d%h want v1 c%0d d%h", k, b_ov, b_oc, b_od, k % 4, mb.d);
      end
    end
  endtask

  task automatic test_rr_sparse();
    for (int k = 0; k < 4; k++) begin
      apply(1'b0, 4'b1010, 2'($urandom), 1'b1, $urandom);
      vectors++;
      if (b_rdy[0] !== 1'b0 || b_rdy[2] !== 1'b0) begin
        errs++; $display("FAIL rr_sparse_ready k=%0d: got %b want ch0/ch2 low", k, b_rdy);
      end
      advance();
      vectors++;
      if (b_ov !== 1'b1 || b_oc !== ((k % 2) ? 2'd3 : 2'd1)) begin
        errs++; $display("FAIL rr_sparse_chan k=%0d: got v%b c%0d want v1 c%0d", k, b_ov, b_oc, (k % 2) ? 3 : 1);
      end
    end
  endtask

  task automatic test_backpressure();
    apply(1'b0, 4'hF, 2'd2, 1'b1, 32'h11A52233);
    advance();
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 4'($urandom), 2'($urandom), 1'b0, $urandom);
      vectors++;
      if (a_rdy !== 4'b0 || a_od !== 8'hA5 || a_ov !== 1'b1) begin
        errs++; $display("FAIL bp_hold k=%0d: got rdy%b d%h v%b want rdy0000 dA5 v1", k, a_rdy, a_od, a_ov);
      end
      advance();
    end
    // Release: every cycle must hand over exactly the word the model expects.
    for (int k = 0; k < 4; k++) begin
      apply(1'b0, 4'hF, 2'($urandom), 1'b1, $urandom);
      vectors++;
      if ({a_rdy, b_rdy, 1'b0, c_rdy} !== {m_ready(MODE_SELECT, 4, ma), m_ready(MODE_RR, 4, mb), m_ready(MODE_SELECT, 3, mc)}) begin
        errs++; $display("FAIL bp_release_ready k=%0d: got %b", k, {a_rdy, b_rdy, c_rdy});
      end
      advance();
      vectors++;
      if ({a_ov, a_od, a_oc, b_ov, b_od, b_oc} !== {ma.v, ma.d, 2'(ma.chan), mb.v, mb.d, 2'(mb.chan)}) begin
        errs++; $display("FAIL bp_release_out k=%0d: got %h want %h", k,
          {a_ov, a_od, a_oc, b_ov, b_od, b_oc}, {ma.v, ma.d, 2'(ma.chan), mb.v, mb.d, 2'(mb.chan)});
      end
    end
  endtask

  task automatic test_sel_invalid();
    apply(1'b0, 4'b1011, 2'd2, 1'b1, $urandom);
    advance();
    vectors++;
    if (a_ov !== 1'b0) begin
      errs++; $display("FAIL sel_no_valid: got out_valid %b want 0", a_ov);
    end
    apply(1'b0, 4'hF, 2'd3, 1'b1, $urandom);
    vectors++;
    if (c_rdy !== 3'b000) begin
      errs++; $display("FAIL sel_oob_ready: got %b want 000", c_rdy);
    end
    advance();
    vectors++;
    if (c_ov !== 1'b0 || a_oc !== 2'd3) begin
      errs++; $display("FAIL sel_oob_out: got c_valid %b a_chan %0d want 0 and 3", c_ov, a_oc);
    end
  endtask

  task automatic test_reset_mid();
    apply(1'b0, 4'hF, 2'd1, 1'b1, $urandom);
    advance();
    apply(1'b1, 4'hF, 2'd1, 1'b0, $urandom);
    vectors++;
    if ({a_rdy, b_rdy, c_rdy} !== 11'b0) begin
      errs++; $display("FAIL rst_mid_ready: got %b want 0", {a_rdy, b_rdy, c_rdy});
    end
    advance();
    vectors++;
    if (a_ov !== 1'b0 || a_od !== 8'h00 || b_ov !== 1'b0 || b_od !== 8'h00) begin
      errs++; $display("FAIL rst_mid_out: got a v%b d%h b v%b d%h want all 0", a_ov, a_od, b_ov, b_od);
    end
    apply(1'b0, 4'hF, 2'd1, 1'b1, $urandom);
    advance();
    vectors++;
    if (b_ov !== 1'b1 || b_oc !== 2'd0) begin
      errs++; $display("FAIL rst_first_grant: got v%b c%0d want v1 c0", b_ov, b_oc);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      apply(($urandom_range(0, 31) == 0), 4'($urandom), 2'($urandom),
            ($urandom_range(0, 9) < 7), $urandom);
      vectors++;
      if ({a_rdy, b_rdy, 1'b0, c_rdy} !== {m_ready(MODE_SELECT, 4, ma), m_ready(MODE_RR, 4, mb), m_ready(MODE_SELECT, 3, mc)}) begin
        errs++; $display("FAIL rand_ready k=%0d: got %b want %b", k, {a_rdy, b_rdy, 1'b0, c_rdy},
          {m_ready(MODE_SELECT, 4, ma), m_ready(MODE_RR, 4, mb), m_ready(MODE_SELECT, 3, mc)});
      end
      advance();
      vectors++;
      if ({a_ov, a_od, a_oc, b_ov, b_od, b_oc, c_ov, c_od, c_oc} !==
          {ma.v, ma.d, 2'(ma.chan), mb.v, mb.d, 2'(mb.chan), mc.v, mc.d, 2'(mc.chan)}) begin
        errs++; $display("FAIL rand_out k=%0d: got %h want %h", k,
          {a_ov, a_od, a_oc, b_ov, b_od, b_oc, c_ov, c_od, c_oc},
          {ma.v, ma.d, 2'(ma.chan), mb.v, mb.d, 2'(mb.chan), mc.v, mc.d, 2'(mc.chan)});
      end
    end
  endtask

  initial begin
    test_reset();
    test_sel_sweep();
    test_rr_all();
    test_rr_sparse();
    test_backpressure();
    test_sel_invalid();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
